serial_adder: RTL

- Bit-serial WIDTH-bit adder built around the single-bit full-adder cell (a, b, c -> sum, carry).
- Loads two operands and a carry-in on a start pulse, then feeds one bit pair per clock, LSB first, through the full-adder cell.
- Registers the carry between cycles and shifts the sum bits into a result register.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. Acts as the sequential controller stage that drives the full adder.

---
 rtl/serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell is reused for every bit position, LSB
// first, with the carry held in a flop between cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               bit_sum;
    logic               bit_carry;
    logic               last_bit;
    logic [WIDTH-1:0]   r_shift;

    // Full-adder cell operating on the current LSBs and the stored carry.
    assign bit_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign r_shift   = WIDTH'({bit_sum, r_sh_q} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; the visible result only changes on the completing edge.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    r_sh_d  = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = r_shift;
                carry_d = bit_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d  = r_shift;
                    cout_d = bit_carry;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_ADD);
        done    = (state_q == S_DONE);
        sum_out = sum_q;
        cout    = cout_q;
    end

endmodule
